rtc_stopwatch_counter: RTL

//   Stopwatch time base and BCD counter. Sits directly downstream of rtc_trigger and consumes its
//   o_count_init / o_count_enb / o_latch_count controls. Divides the system clock to a 10 ms tick,

---
 rtl/rtc_stopwatch_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rtc_stopwatch_counter.sv
// rtc_stopwatch_counter
//   Stopwatch time base and BCD counter. It divides the system clock down to a
//   TICK_HZ tick and keeps a live MM:SS.CC count. It also drives a display
//   register that can be frozen for a lap while the live count keeps running.
//
// Parameters
//   CLK_FREQ_HZ    system clock frequency
//   TICK_HZ        count tick rate; DIV = CLK_FREQ_HZ / TICK_HZ, DIV >= 2
//
// Ports
//   i_sclk         system clock; all logic runs on its rising edge
//   i_reset_n      synchronous active-low reset
//   i_count_init   clears the prescaler, the live count and the display
//   i_count_enb    advances the prescaler and the live count
//   i_latch_count  freezes the display; the live count keeps running
//   o_live         live BCD {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
//   o_disp         display BCD, same packing; lags o_live by one cycle
//   o_tick         one-cycle pulse on every live-count increment
//   o_rollover     one-cycle pulse when the count wraps 59:59.99 -> 00:00.00
module rtc_stopwatch_counter #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 100
) (
    input  logic        i_sclk,
    input  logic        i_reset_n,
    input  logic        i_count_init,
    input  logic        i_count_enb,
    input  logic        i_latch_count,
    output logic [23:0] o_live,
    output logic [23:0] o_disp,
    output logic        o_tick,
    output logic        o_rollover
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   live_q, live_d;
    logic [23:0]   disp_q, disp_d;
    logic          tick_q, tick_d;
    logic          roll_q, roll_d;

    logic [23:0]   live_inc;
    logic          live_wrap;

    // Largest legal value of each digit, least significant digit first.
    function automatic logic [3:0] digit_max(input int unsigned idx);
        case (idx)
            3, 5:    digit_max = 4'd5;
            default: digit_max = 4'd9;
        endcase
    endfunction

    // Ripple the +1 from cs_u upwards. A digit at or above its limit wraps to
    // zero and passes the carry on. A carry out of min_t means 59:59.99 wrapped.
    always_comb begin
        logic carry;
        live_inc = live_q;
        carry    = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            if (carry) begin
                if (live_q[i*4 +: 4] >= digit_max(i)) begin
                    live_inc[i*4 +: 4] = '0;
                end else begin
                    live_inc[i*4 +: 4] = live_q[i*4 +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        live_wrap = carry;
    end

    always_comb begin
        presc_d = presc_q;
        live_d  = live_q;
        disp_d  = disp_q;
        tick_d  = 1'b0;
        roll_d  = 1'b0;
        if (i_count_init) begin
            presc_d = '0;
            live_d  = '0;
            disp_d  = '0;
        end else begin
            // The display copies the pre-increment live value, so it trails
            // o_live by exactly one cycle.
            if (!i_latch_count) begin
                disp_d = live_q;
            end
            if (i_count_enb) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    live_d  = live_inc;
                    tick_d  = 1'b1;
                    roll_d  = live_wrap;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            live_q  <= '0;
            disp_q  <= '0;
            tick_q  <= 1'b0;
            roll_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            live_q  <= live_d;
            disp_q  <= disp_d;
            tick_q  <= tick_d;
            roll_q  <= roll_d;
        end
    end

    assign o_live     = live_q;
    assign o_disp     = disp_q;
    assign o_tick     = tick_q;
    assign o_rollover = roll_q;

endmodule
